// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the iterative multiply/divide unit.
// Op codes, FSM states, iteration count and divide-by-zero quotient.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } mdOp_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } mdState_t;

  localparam int MD_ITER = 32;
  localparam logic [31:0] MD_DIV0_LO = 32'hFFFFFFFF;

  function automatic logic opIsDiv(logic [1:0] o);
    return o[1];
  endfunction

  function automatic logic opIsSigned(logic [1:0] o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/md_step.sv
// md_step: one combinational shift-add / restoring-divide iteration.
// Ports: isDiv, acc, opnd in; nextAcc (quotient bit slot left 0), qBit out.
module md_step #(
  parameter int W = 32
) (
  input  logic           isDiv,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  output logic [2*W-1:0] nextAcc,
  output logic           qBit
);

  logic [W:0] sum;
  logic [W:0] trial;

  always_comb begin
    sum     = {1'b0, acc[2*W-1:W]}
            + (acc[0] ? {1'b0, opnd} : '0);
    // top W+1 bits of the left-shifted {rem, quot} pair
    trial   = acc[2*W-1:W-1] - {1'b0, opnd};
    qBit    = 1'b0;
    nextAcc = '0;
    if (isDiv) begin
      qBit    = ~trial[W];
      nextAcc = {qBit ? trial[W-1:0] : acc[2*W-2:W-1],
                 acc[W-2:0], 1'b0};
    end else begin
      nextAcc = {sum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_seq.sv
// mul_div_seq: 32-iteration MULT/MULTU/DIV/DIVU sequencer for EX.
// In: clock, reset(n), start, op, src_a, src_b, flush. Out: stall, done, hi, lo.
module mul_div_seq
  import md_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int W     = DATA_W;
  localparam int CNT_W = $clog2(DATA_W);

  mdState_t       state;
  logic [CNT_W-1:0] cnt;
  logic           isDivR;
  logic           signA;
  logic           signB;
  logic [W-1:0]   opnd;
  logic [2*W-1:0] acc;

  logic           opDiv;
  logic           opSgn;
  logic [W-1:0]   absA;
  logic [W-1:0]   absB;
  logic [2*W-1:0] stepAcc;
  logic           qBit;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;

  assign opDiv = opIsDiv(op);
  assign opSgn = opIsSigned(op);
  assign absA  = (opSgn & src_a[W-1]) ? -src_a : src_a;
  assign absB  = (opSgn & src_b[W-1]) ? -src_b : src_b;

  md_step #(.W(W)) uStep (
    .isDiv  (isDivR),
    .acc    (acc),
    .opnd   (opnd),
    .nextAcc(stepAcc),
    .qBit   (qBit)
  );

  // signs are latched as 0 for unsigned ops, so fix-up is a no-op there
  assign prod = (signA ^ signB) ? -acc : acc;
  assign quot = (signA ^ signB) ? -acc[W-1:0] : acc[W-1:0];
  assign rem  = signA ? -acc[2*W-1:W] : acc[2*W-1:W];

  assign stall = (state == MD_IDLE & start & ~flush)
               | (state == MD_RUN)
               | (state == MD_FIX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      isDivR <= 1'b0;
      signA  <= 1'b0;
      signB  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= MD_IDLE;
      end else begin
        unique case (state)
          MD_IDLE: begin
            if (start) begin
              isDivR <= opDiv;
              signA  <= opSgn & src_a[W-1];
              signB  <= opSgn & src_b[W-1];
              cnt    <= '0;
              if (opDiv && src_b == '0) begin
                hi    <= src_a;
                lo    <= MD_DIV0_LO;
                done  <= 1'b1;
                state <= MD_DONE;
              end else begin
                // div: acc={rem,dividend}, opnd=divisor
                // mul: acc={0,multiplier}, opnd=multiplicand
                acc   <= {{W{1'b0}}, opDiv ? absA : absB};
                opnd  <= opDiv ? absB : absA;
                state <= MD_RUN;
              end
            end
          end
          MD_RUN: begin
            acc <= stepAcc | {{(2*W-1){1'b0}}, qBit};
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(MD_ITER - 1)) state <= MD_FIX;
          end
          MD_FIX: begin
            hi    <= isDivR ? rem  : prod[2*W-1:W];
            lo    <= isDivR ? quot : prod[W-1:0];
            done  <= 1'b1;
            state <= MD_DONE;
          end
          MD_DONE: state <= MD_IDLE;
          default: state <= MD_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq: scoreboard bench for mul_div_seq.
// Directed corner ops, flush/reset cases, then random back-to-back ops.
module tb_mul_div_seq;
  import md_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clock = ~clock;

  mul_div_seq #(.DATA_W(32)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .op   (op),
    .src_a(srcA),
    .src_b(srcB),
    .flush(flush),
    .stall(stall),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          stl;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          issueCyc = 0;
  int          stallCnt = 0;
  logic [63:0] lastRes = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: plain 64-bit arithmetic, C-style truncating division
  function automatic logic [63:0] model(logic [1:0] o,
                                        logic [31:0] a,
                                        logic [31:0] b);
    longint sa, sb2, q, r;
    logic [63:0] ua, ub;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (o)
      2'd0: return 64'(sa * sb2);
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb2;
        r = sa % sb2;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {(ua % ub) << 32} | (ua / ub);
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // monitor: pops expectations whenever the DUT signals done
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (stall) stallCnt++;
      if (done) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          e = sb.pop_front();
          check("hi", {32'd0, hi}, {32'd0, e.res[63:32]});
          check("lo", {32'd0, lo}, {32'd0, e.res[31:0]});
          check("latency", 64'(cyc - issueCyc), 64'(e.lat));
          check("stall_cycles", 64'(stallCnt), 64'(e.stl));
          lastRes = e.res;
        end
      end
    end
  end

  // called at posedge+#1; returns at posedge+#1 after DONE
  task automatic issue(logic [1:0] o, logic [31:0] a,
                       logic [31:0] b);
    logic got;
    logic div0;
    exp_t e;
    op       = o;
    srcA     = a;
    srcB     = b;
    start    = 1'b1;
    issueCyc = cyc;
    stallCnt = 0;
    div0     = o[1] && (b == 0);
    e.res    = model(o, a, b);
    e.lat    = div0 ? 1 : 34;
    e.stl    = div0 ? 1 : 34;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock);
      got = done;
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: got no done expected done op=%0d", o);
      sb.delete();
    end
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic noDone(string name, int n);
    logic saw;
    saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (done) saw = 1'b1;
    end
    check(name, {63'd0, saw}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("tp_multu", {hi, lo}, 64'hFFFFFFFE_00000001);
    issue(2'd0, 32'hFFFFFFFF, 32'd2);
    check("tp_mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    issue(2'd0, 32'h80000000, 32'h80000000);
    check("tp_mult_min", {hi, lo}, 64'h40000000_00000000);
    issue(2'd2, 32'hFFFFFFF9, 32'd2);
    check("tp_div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(2'd3, 32'd100, 32'd7);
    check("tp_divu", {hi, lo}, 64'h00000002_0000000E);
    issue(2'd2, 32'd5, 32'd0);
    check("tp_div0", {hi, lo}, 64'h00000005_FFFFFFFF);

    // flush in RUN cycle 10 of a DIVU
    op    = 2'd3;
    srcA  = $urandom();
    srcB  = 32'd3;
    start = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    flush = 1'b1;
    start = 1'b0;
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    check("flush_stall", {63'd0, stall}, 64'd0);
    noDone("flush_no_done", 40);
    check("flush_keep", {hi, lo}, lastRes);

    // flush together with start in IDLE
    @(posedge clock);
    #1;
    op    = 2'd1;
    srcA  = 32'd9;
    srcB  = 32'd9;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clock);
    check("flush_start_stall", {63'd0, stall}, 64'd0);
    @(posedge clock);
    #1;
    start = 1'b0;
    flush = 1'b0;
    noDone("flush_start_no_done", 40);
    check("flush_start_keep", {hi, lo}, lastRes);

    // asynchronous reset mid-RUN
    @(posedge clock);
    #1;
    op    = 2'd1;
    srcA  = $urandom();
    srcB  = $urandom();
    start = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    start = 1'b0;
    reset = 1'b0;
    #1;
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_stall", {63'd0, stall}, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    issue(2'd1, 32'd3, 32'd4);
    check("tp_after_rst", {hi, lo}, 64'd12);

    // random back-to-back traffic
    for (int n = 0; n < 40; n++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick());
    end

    repeat (3) @(negedge clock);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
